wb_ddr_arbiter: RTL

- Round-robin Wishbone arbiter that shares the single 128-bit DDR3 Wishbone port (wb_ddr3 slave side) among NUM_MASTERS requesters, e.g. I-cache, D-cache and DMA/video.
- Sits in the wb_clk_i domain, directly in front of the DDR3 bridge.
- Enforces fairness with a per-grant transfer cap.
- Protects masters with an ack watchdog that returns an error and quarantines the late ack.

---
 rtl/wb_ddr_arb_pkg.sv | 15 +
 rtl/wb_ddr_arbiter_rr.sv | 32 +++
 rtl/wb_ddr_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_ddr_arb_pkg.sv
// Shared types and bus widths for the DDR3 Wishbone arbiter.
// Imported by the arbiter top and its round-robin core.
package wb_ddr_arb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 128;
  localparam int WB_SEL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    QUAR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_ddr_arbiter_rr.sv
// Combinational round-robin pick: first requester after the pointer,
// wrapping, returned as one-hot grant plus its index.
module rr_arbiter_core #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from ptr+1 upward; the first hit wins.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone arbiter in front of the 128-bit DDR3 port,
// with a per-grant transfer cap and an ack watchdog.
module wb_ddr_arbiter
  import wb_ddr_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_XFERS   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            timeout_o
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [7:0] XFER_LAST = 8'(MAX_XFERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [7:0]             xfer_q, xfer_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [PW-1:0]          pick_idx;
  logic                   pick_vld;
  logic [PW-1:0]          sel_idx;
  logic                   g_cyc, g_stb, tmo_hit;

  assign req = m_cyc_i & m_stb_i;

  rr_arbiter_core #(.N(NUM_MASTERS), .PW(PW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // The pointer holds the owner index while OWN/QUAR; idle muxes master 0.
  assign sel_idx = (state_q == IDLE) ? '0 : ptr_q;
  assign g_cyc   = m_cyc_i[ptr_q];
  assign g_stb   = m_stb_i[ptr_q];
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST) &&
                   g_stb && !s_ack_i;

  assign s_adr_o   = m_adr_i[int'(sel_idx)*WB_ADR_W +: WB_ADR_W];
  assign s_sel_o   = m_sel_i[int'(sel_idx)*WB_SEL_W +: WB_SEL_W];
  assign s_dat_o   = m_dat_i[int'(sel_idx)*WB_DAT_W +: WB_DAT_W];
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  // State, grant, pointer and counters.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PW'(NUM_MASTERS - 1);
      xfer_q    <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      xfer_q    <= xfer_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: grant, cap / release / watchdog exits, quarantine drain.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    xfer_d    = xfer_q;
    tmo_d     = '0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        xfer_d = '0;
        if (pick_vld) begin
          grant_d = pick_gnt;
          ptr_d   = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (g_stb && !s_ack_i) tmo_d = tmo_q + 1'b1;
        if (s_ack_i) xfer_d = xfer_q + 8'd1;
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_ack_i && xfer_q == XFER_LAST) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tmo_hit) begin
          state_d   = QUAR;
          timeout_d = 1'b1;
          tmo_d     = '0;
        end
      end
      QUAR: begin
        if (s_ack_i) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slave-side controls and per-master ack/err steering.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      OWN: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = m_we_i[ptr_q];
        m_ack_o = s_ack_i ? grant_q : '0;
        m_err_o = tmo_hit ? grant_q : '0;
      end
      QUAR: begin
        s_cyc_o = 1'b1;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule
